// File: rtl/input_fifo_rx.sv
// Router input-port receive buffer: answers upstream RTS (DRTS) with a one-cycle CTS,
// queues flits in a circular buffer, pops on any local grant. Optional err flag: FIFO_RX_ERR_EN.
module input_fifo_rx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    input  logic [DATA_WIDTH-1:0] RX,
    output logic                  CTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_RX_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic                  read_en;
    logic                  do_write;
    logic                  do_pop;

    assign read_en  = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    assign do_write = CTS & DRTS;
    assign do_pop   = read_en & ~empty;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign Data_out = empty ? '0 : mem[rd_ptr];

    // The ~CTS term spaces handshakes two cycles apart, so full cannot rise
    // between issuing CTS and the write it grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            CTS    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            CTS <= DRTS & ~CTS & ~full;
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(do_write) - (PTR_W + 1)'(do_pop);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[wr_ptr] <= RX;
        end
    end

`ifdef FIFO_RX_ERR_EN
    logic [2:0] n_rd;

    assign n_rd = 3'(read_en_N) + 3'(read_en_E) + 3'(read_en_W) + 3'(read_en_S) + 3'(read_en_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((read_en && empty) || (n_rd > 3'd1)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_input_fifo_rx.sv
// Self-checking bench for input_fifo_rx: directed plan then randomized traffic vs a queue model.
module tb_input_fifo_rx;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          drts;
    logic [DW-1:0] rx;
    logic          cts;
    logic [4:0]    rd;   // {L,S,W,E,N}
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_RX_ERR_EN
    logic          err;
`endif

    input_fifo_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .DRTS      (drts),
        .RX        (rx),
        .CTS       (cts),
        .read_en_N (rd[0]),
        .read_en_E (rd[1]),
        .read_en_W (rd[2]),
        .read_en_S (rd[3]),
        .read_en_L (rd[4]),
        .Data_out  (data_out),
        .empty     (empty),
        .full      (full)
`ifdef FIFO_RX_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [DW-1:0] q[$];
    bit            cts_m = 1'b0;
    bit            err_m = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the values present at the edge, then compare.
    task automatic step();
        int  nrd;
        bit  wr;
        bit  pop;
        bit  full_m;
        @(posedge clk);
        nrd    = $countones(rd);
        full_m = (q.size() == DEPTH);
        if (rst) begin
            q.delete();
            cts_m = 1'b0;
            err_m = 1'b0;
        end else begin
            wr    = cts_m && drts;
            pop   = (nrd > 0) && (q.size() != 0);
            err_m = err_m || ((nrd > 0) && (q.size() == 0)) || (nrd > 1);
            cts_m = drts && !cts_m && !full_m;
            if (pop) void'(q.pop_front());
            if (wr) q.push_back(rx);
        end
        #1;
        check("cts",      DW'(cts),   DW'(cts_m));
        check("empty",    DW'(empty), DW'(q.size() == 0));
        check("full",     DW'(full),  DW'(q.size() == DEPTH));
        check("data_out", data_out,   (q.size() != 0) ? q[0] : '0);
`ifdef FIFO_RX_ERR_EN
        check("err",      DW'(err),   DW'(err_m));
`endif
    endtask

    // Upstream sender: hold DRTS/RX until CTS, write on that edge, then idle one cycle.
    task automatic send(input logic [DW-1:0] d);
        bit got = 1'b0;
        bit was;
        drts = 1'b1;
        rx   = d;
        for (int i = 0; i < 12 && !got; i++) begin
            was = cts_m;
            step();
            if (was) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL send_timeout: observed=no_cts expected=cts for %h", d);
        end
        drts = 1'b0;
        step();
    endtask

    initial begin
        bit hold_off;
        bit was;
        int r;

        rst = 1'b1; drts = 1'b0; rx = '0; rd = '0;
        step();
        step();
        rst = 1'b0;

        // First handshake and fall-through
        send(32'hA5A5_0001);
        check("first_flit", data_out, 32'hA5A5_0001);
        rd = 5'b00001; step(); rd = '0;

        // Fill, then a held request that must stay unanswered
        for (int i = 1; i <= 4; i++) send(DW'(i));
        check("full_after_4", DW'(full), 1);
        drts = 1'b1; rx = 32'd5;
        for (int i = 0; i < 4; i++) step();
        check("cts_blocked", DW'(cts), 0);

        // One pop from full frees a slot; CTS follows the next cycle
        rd = 5'b00010; step(); rd = '0;
        check("pop_head", data_out, 32'd2);
        step();
        check("cts_after_pop", DW'(cts), 1);
        step();
        drts = 1'b0; step();

        // Drain to one flit, then coincident write+pop (second one wraps wr_ptr 3->0)
        rd = 5'b00001;
        for (int i = 0; i < 3; i++) step();
        rd = '0;
        for (int k = 6; k <= 7; k++) begin
            drts = 1'b1; rx = DW'(k);
            step();
            rd = 5'b00001; step(); rd = '0;
            check("coincide", data_out, DW'(k));
            drts = 1'b0; step();
        end

        // Multi-grant counts as one pop; then pops on empty are ignored
        send(32'd8);
        rd = 5'b11111; step();
        check("multi_pop", data_out, 32'd8);
        step();
        rd = 5'b10000; step(); step(); rd = '0;
        check("empty_pop", DW'(empty), 1);
        step();

        // Reset on the CTS cycle discards the flit; handshake restarts
        drts = 1'b1; rx = 32'd9;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_no_write", DW'(empty), 1);
        step();
        check("cts_restart", DW'(cts), 1);
        step();
        drts = 1'b0; step();

        // Randomized traffic obeying the upstream protocol
        hold_off = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!drts && !hold_off && ($urandom_range(0, 1) == 1)) begin
                drts = 1'b1;
                rx   = $urandom;
            end
            r = $urandom_range(0, 9);
            if (r < 4)      rd = '0;
            else if (r < 8) rd = 5'(1 << $urandom_range(0, 4));
            else            rd = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) == 0);
            hold_off = 1'b0;
            was = cts_m;
            step();
            if (rst) begin
                drts = 1'b0;
            end else if (was && drts) begin
                drts = 1'b0;
                hold_off = 1'b1;
            end
        end
        rst = 1'b0; rd = '0; drts = 1'b0;
        step();

        rst = 1'b1; step(); rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_fifo_rx.md
Name: input_fifo_rx

Overview:
- Receive-side counterpart of the router output arbiter's RTS/DCTS handshake; sits at each router input port (N/E/W/S/L).
- Answers the upstream arbiter's RTS with a one-cycle CTS pulse, which the upstream sees as DCTS.
- Captures the flit on the handshake cycle into a small circular buffer.
- Presents the head flit to the local output arbiters/crossbar, popped by their grants.

Parameters:
DATA_WIDTH, 32, flit width in bits
DEPTH, 4, buffer entries; power of two, >= 2
PTR_W, log2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
DRTS  input  1  request-to-send from upstream arbiter (its RTS)
RX  input  DATA_WIDTH  flit from upstream crossbar; valid while DRTS=1
CTS  output  1  clear-to-send pulse to upstream (its DCTS)
read_en_N  input  1  pop request from North output arbiter (its Grant for this port)
read_en_E  input  1  pop request from East output arbiter
read_en_W  input  1  pop request from West output arbiter
read_en_S  input  1  pop request from South output arbiter
read_en_L  input  1  pop request from Local output arbiter
Data_out  output  DATA_WIDTH  head flit; combinational from buffer; 0 when empty
empty  output  1  buffer holds no flits
full  output  1  buffer holds DEPTH flits

Behaviour:
- Reset (rst=1 at clock edge): CTS=0, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, Data_out=0. Buffer storage is not cleared. Reset mid-handshake discards any pending flit, and CTS is 0 on the following cycle.
- CTS is a register. CTS_next = DRTS & ~CTS & ~full. CTS is never high two consecutive cycles.
- Write: when CTS=1 and DRTS=1 at a clock edge, store RX at mem[wr_ptr], wr_ptr++ (mod DEPTH), count++. No write at any other time.
- Full cannot change from 0 to 1 between CTS issue and the write, because the ~CTS term blocks back-to-back writes. Writes therefore never overflow.
- Upstream protocol: the sender holds RX and DRTS until it sees CTS, then drops DRTS for at least one cycle. If DRTS falls while CTS=1, no write occurs.
- read_en = OR of the five read_en_* inputs. Pop when read_en=1 and empty=0: rd_ptr++ (mod DEPTH), count--.
- A pop on empty is ignored, with no pointer change.
- Multiple read_en_* high in one cycle counts as a single pop.
- Simultaneous write and pop: both occur; count is unchanged.
- When full with a pop in the same cycle, the pop proceeds. CTS is not issued that cycle because full was 1; it is issued next cycle if DRTS is still high.
- empty = (count==0); full = (count==DEPTH).
- count is PTR_W+1 bits. Pointers wrap naturally.
- Data_out = mem[rd_ptr] when empty=0, else 0 (first-word fall-through). A written flit appears on Data_out the cycle after the write edge.
- Latency:
  - DRTS rise to CTS: 1 cycle.
  - DRTS rise to flit visible: 2 cycles (with buffer empty).
  - Max sustained throughput: 1 flit per 2 cycles, matching the arbiter's RTS drop-after-DCTS cadence.

Optional Feature:
- Macro FIFO_RX_ERR_EN.
- Defined: adds output err (1 bit, reset 0).
  - err is a sticky register set at any clock edge where read_en=1 while empty=1, or where two or more read_en_* are high.
  - err is cleared only by rst.
  - Functional behaviour is otherwise identical.
- Undefined: err port and logic are absent; these conditions are silently ignored as described above.

Test Plan:
- Reset then DRTS=1, RX=0xA5A5_0001 held: CTS=1 in cycle 1 only. After the edge with CTS=1, empty=0 and Data_out=0xA5A5_0001.
- Four handshakes with RX=1,2,3,4 and no reads: full=1 after the 4th write. A 5th DRTS held high gives CTS=0 indefinitely.
- From full, pulse read_en_E=1 for one cycle: Data_out goes 1->2 and full=0. The next cycle CTS=1 for the waiting flit 5.
- Buffer holding one flit, with write edge and read_en_N coinciding: count stays 1 and Data_out becomes the new flit. Verify a wrap case with wr_ptr 3->0.
- read_en_L=1 on empty: pointers unchanged, Data_out=0, empty=1. With FIFO_RX_ERR_EN, err=1 and it stays 1 until rst.
- rst asserted on the cycle CTS=1 with DRTS=1: no write, empty=1, CTS=0 next cycle. Afterwards the handshake restarts normally.
